// File: rtl/audio_pkg.sv
// Shared constants for the triangle-voice sequencer: voice count default,
// phase wrap point, the phase slice used as the voice level, and FSM encoding.
package audio_pkg;

  localparam int NUM_VOICES_DEF = 8;

  localparam logic [31:0] PHASE_MAX = 32'h1000_0000;

  localparam int PH_HI   = 27;
  localparam int PH_LO   = 8;
  localparam int PH_BITS = PH_HI - PH_LO + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

endpackage

// File: rtl/phase_wrap_add.sv
// Combinational phase step: phase + increment, folded back once at PHASE_MAX.
// The add is one bit wider than the phase so a carry can never be lost.
module phase_wrap_add
  import audio_pkg::*;
#(
  parameter int PHASE_W = 32
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PHASE_W-1:0] inc_i,
  output logic [PHASE_W-1:0] sum_o
);

  localparam logic [PHASE_W:0] MAX_EXT = (PHASE_W + 1)'(PHASE_MAX);

  logic [PHASE_W:0] raw_sum;
  logic [PHASE_W:0] folded;
  logic             unused_msb;

  assign raw_sum = {1'b0, phase_i} + {1'b0, inc_i};
  assign folded  = (raw_sum >= MAX_EXT) ? (raw_sum - MAX_EXT) : raw_sum;
  assign {unused_msb, sum_o} = folded;

endmodule

// File: rtl/voice_sequencer.sv
// Time-multiplexed triangle-voice mixer: one voice per cycle through a single
// shared phase adder, producing one mixed sample per sample_req.
module voice_sequencer
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = 32,
  parameter int SAMPLE_W   = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_req,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic                          inc_wr,
  input  logic [$clog2(NUM_VOICES)-1:0] inc_idx,
  input  logic [PHASE_W-1:0]            inc_data,
  output logic [SAMPLE_W-1:0]           sample_out,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      v_q, v_d;
  logic [NUM_VOICES-1:0] snap_q, snap_d;
  logic [SAMPLE_W-1:0]   sum_q, sum_d;
  logic [SAMPLE_W-1:0]   out_q, out_d;
  logic                  valid_q, valid_d;

  logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];

  logic [PHASE_W-1:0]    phase_cur, inc_cur, phase_nxt;
  logic [SAMPLE_W-1:0]   contrib, sum_acc;
  logic                  xfer, accept, last_voice;

  assign phase_cur = phase_q[v_q];
  assign inc_cur   = inc_q[v_q];

  phase_wrap_add #(.PHASE_W(PHASE_W)) u_wrap_add (
    .phase_i (phase_cur),
    .inc_i   (inc_cur),
    .sum_o   (phase_nxt)
  );

  // Level is taken from the phase before this sample's advance.
  assign contrib    = snap_q[v_q] ? SAMPLE_W'(phase_cur[PH_HI:PH_LO]) : '0;
  assign sum_acc    = sum_q + contrib;
  assign last_voice = (v_q == IDX_W'(NUM_VOICES - 1));

  assign xfer   = valid_q && sample_ready;
  assign accept = sample_req && ((state_q == ST_IDLE) || ((state_q == ST_OUT) && xfer));

  assign overrun      = !reset && sample_req &&
                        ((state_q == ST_ACCUM) || ((state_q == ST_OUT) && !xfer));
  assign busy         = (state_q != ST_IDLE);
  assign sample_out   = out_q;
  assign sample_valid = valid_q;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    snap_d  = snap_q;
    sum_d   = sum_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: ;
      ST_ACCUM: begin
        sum_d = sum_acc;
        v_d   = v_q + 1'b1;
        if (last_voice) begin
          state_d = ST_OUT;
          out_d   = sum_acc >> 2;
          valid_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A request on the transfer cycle chains straight into the next sample.
    if (accept) begin
      state_d = ST_ACCUM;
      snap_d  = voice_en;
      sum_d   = '0;
      v_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      snap_q  <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      snap_q  <= snap_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Only phase[v] moves per cycle, so every voice still advances once per sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
      end
    end else begin
      if (state_q == ST_ACCUM) phase_q[v_q] <= phase_nxt;
      if (inc_wr) inc_q[inc_idx] <= inc_data;
    end
  end

endmodule

// File: tb/tb_voice_sequencer.sv
// Randomized and directed bench for voice_sequencer against a sample-level
// reference model (whole mixed sample computed at the moment a request is accepted).
module tb_voice_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset, sample_req, inc_wr, sample_ready;
  logic [N-1:0] voice_en;
  logic [2:0]  inc_idx;
  logic [31:0] inc_data;
  logic [23:0] sample_out;
  logic        sample_valid, busy, overrun;

  always #5 clk = ~clk;

  voice_sequencer dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .voice_en(voice_en),
    .inc_wr(inc_wr), .inc_idx(inc_idx), .inc_data(inc_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;
  int ovr_count = 0;

  longint unsigned mph  [N];
  longint unsigned minc [N];
  int              acc_left = 0;
  bit              mvalid = 0;
  logic [31:0]     mout = '0;
  logic [31:0]     pending = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned wrap_step(longint unsigned p, longint unsigned i);
    longint unsigned s = p + i;
    return (s >= 64'h1000_0000) ? s - 64'h1000_0000 : s;
  endfunction

  // One clock: check combinational overrun, clock the DUT and the model, check outputs.
  task automatic cyc();
    bit exp_ovr, idle, xfer;
    longint unsigned acc;
    #1;
    exp_ovr = !reset && sample_req && (acc_left > 0 || (mvalid && !sample_ready));
    chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
    if (overrun === 1'b1) ovr_count++;
    @(posedge clk);
    if (reset) begin
      foreach (mph[i]) begin mph[i] = 0; minc[i] = 0; end
      acc_left = 0; mvalid = 0; mout = '0; pending = '0;
    end else begin
      xfer = mvalid && sample_ready;
      idle = (acc_left == 0) && !mvalid;
      if (inc_wr) minc[inc_idx] = inc_data;
      if (acc_left > 0) begin
        acc_left--;
        if (acc_left == 0) begin mvalid = 1; mout = pending; end
      end else if (xfer) mvalid = 0;
      if (sample_req && (idle || xfer)) begin
        acc = 0;
        for (int i = 0; i < N; i++) begin
          if (voice_en[i]) acc += (mph[i] >> 8) & 64'hF_FFFF;
          mph[i] = wrap_step(mph[i], minc[i]);
        end
        pending  = 32'(acc >> 2);
        acc_left = N;
      end
    end
    #1;
    chk("valid", {31'b0, sample_valid}, {31'b0, mvalid});
    chk("busy", {31'b0, busy}, {31'b0, (acc_left > 0 || mvalid)});
    chk("out", {8'b0, sample_out}, mout);
  endtask

  task automatic do_reset();
    reset = 1; sample_req = 0; inc_wr = 0; inc_idx = '0; inc_data = '0;
    voice_en = '0; sample_ready = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic write_inc(input int idx, input logic [31:0] d);
    inc_wr = 1; inc_idx = 3'(idx); inc_data = d;
    cyc();
    inc_wr = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (sample_valid !== 1'b1 && lat < 40) begin cyc(); lat++; end
  endtask

  task automatic get_sample(output logic [31:0] o, output int lat);
    sample_req = 1; sample_ready = 1;
    cyc();
    sample_req = 0;
    wait_valid(lat);
    o = {8'b0, sample_out};
    cyc();
  endtask

  initial begin
    logic [31:0] o, hold;
    int lat;

    // Single voice, first sample at phase 0, second at one increment.
    do_reset();
    write_inc(0, 32'h0100_0000);
    voice_en = '1;
    get_sample(o, lat);
    chk("first_latency", lat, N);
    chk("first_sample", o, 32'h0);
    get_sample(o, lat);
    chk("second_sample", o, 32'h4000);

    // Voice 3 wraps on its second advance.
    do_reset();
    write_inc(3, 32'h0F00_0000);
    voice_en = 8'h08;
    get_sample(o, lat); chk("wrap_s0", o, 32'h0);
    get_sample(o, lat); chk("wrap_s1", o, 32'h3C000);
    get_sample(o, lat); chk("wrap_s2", o, 32'h38000);

    // Back-pressure in OUT with a dropped request.
    do_reset();
    write_inc(0, 32'h0100_0000);
    voice_en = '1;
    get_sample(o, lat);
    sample_req = 1; sample_ready = 0;
    cyc();
    sample_req = 0;
    wait_valid(lat);
    hold = {8'b0, sample_out};
    chk("stall_value", hold, 32'h4000);
    ovr_count = 0;
    for (int c = 0; c < 20; c++) begin
      sample_req = (c == 5);
      cyc();
      chk("stall_hold", {8'b0, sample_out}, hold);
    end
    sample_req = 0;
    chk("overrun_pulses", ovr_count, 1);
    sample_ready = 1;
    cyc();
    chk("stall_release", {31'b0, sample_valid}, 32'h0);

    // Request on the transfer cycle chains directly.
    sample_req = 1;
    cyc();
    sample_req = 0;
    wait_valid(lat);
    ovr_count = 0;
    sample_req = 1;
    cyc();
    sample_req = 0;
    chk("chain_busy", {31'b0, busy}, 32'h1);
    chk("chain_no_overrun", ovr_count, 0);
    wait_valid(lat);
    chk("chain_latency", lat, N);
    cyc();

    // Snapshot isolation: enables change mid-accumulation.
    do_reset();
    for (int i = 0; i < N; i++) write_inc(i, 32'(i + 1) * 32'h0010_0000);
    voice_en = '0;
    get_sample(o, lat); chk("snap_s0", o, 32'h0);
    voice_en = 8'h01; sample_req = 1;
    cyc();
    sample_req = 0; voice_en = 8'hFF;
    wait_valid(lat);
    chk("snap_s1", {8'b0, sample_out}, 32'h400);
    cyc();
    get_sample(o, lat); chk("snap_s2", o, 32'h12000);

    // Reset in the middle of accumulation discards the sample.
    sample_req = 1;
    cyc();
    sample_req = 0;
    repeat (4) cyc();
    reset = 1;
    cyc();
    reset = 0;
    chk("rst_valid", {31'b0, sample_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_out", {8'b0, sample_out}, 32'h0);
    repeat (20) cyc();
    voice_en = '1;
    get_sample(o, lat); chk("rst_phase_zero", o, 32'h0);

    // Increment write to the voice being processed takes effect next sample.
    do_reset();
    write_inc(2, 32'h0100_0000);
    voice_en = 8'h04;
    sample_req = 1; cyc(); sample_req = 0;
    cyc(); cyc();
    inc_wr = 1; inc_idx = 3'd2; inc_data = 32'h0200_0000;
    cyc();
    inc_wr = 0;
    wait_valid(lat);
    chk("incwr_s0", {8'b0, sample_out}, 32'h0);
    cyc();
    get_sample(o, lat); chk("incwr_s1", o, 32'h4000);
    get_sample(o, lat); chk("incwr_s2", o, 32'hC000);

    // Randomized traffic; mid-sample increment writes only touch voices already processed.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int idx;
      reset        = ($urandom_range(299) == 0);
      sample_req   = ($urandom_range(3) == 0);
      voice_en     = N'($urandom);
      sample_ready = $urandom_range(1);
      idx          = $urandom_range(N - 1);
      inc_idx      = 3'(idx);
      inc_data     = $urandom & 32'h0FFF_FFFF;
      inc_wr       = ((acc_left == 0) || (idx <= N - acc_left)) && ($urandom_range(5) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of time-multiplexed triangle voices (power of two, 2..16).
REQ-002 SHALL have parameter PHASE_W, default 32, phase accumulator and increment width.
REQ-003 SHALL have parameter SAMPLE_W, default 24, mixed sample width.
REQ-004 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_req  in  1  one-cycle strobe requesting one new mixed sample (sample-rate tick).
REQ-007 SHALL have port voice_en  in  NUM_VOICES  per-voice gate (e.g. decoded button state).
REQ-008 SHALL have port inc_wr  in  1  write strobe for a phase increment.
REQ-009 SHALL have port inc_idx  in  $clog2(NUM_VOICES)  voice index for inc_wr.
REQ-010 SHALL have port inc_data  in  PHASE_W  phase increment value.
REQ-011 SHALL have port sample_out  out  SAMPLE_W  mixed sample, valid while sample_valid=1.
REQ-012 SHALL have port sample_valid  out  1  output handshake valid.
REQ-013 SHALL have port sample_ready  in  1  downstream (i2s) ready.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port overrun  out  1  one-cycle pulse when a sample_req is dropped.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, OUT.
REQ-017 IDLE: on sample_req SHALL snapshot voice_en, clear sum, set voice index v=0, go ACCUM.
REQ-018 ACCUM: each cycle SHALL process exactly one voice v, advancing phase[v] and adding its contribution to sum; after v=NUM_VOICES-1 go OUT.
REQ-019 Phase update SHALL be p' = p+inc; if p' >= PHASE_MAX (0x1000_0000) then p' = p+inc-PHASE_MAX; computed at PHASE_W+1 bits, no silent overflow.
REQ-020 Phase SHALL advance for every voice every sample regardless of voice_en (continuous phase).
REQ-021 Contribution SHALL be the pre-update phase bits [27:8] zero-extended to SAMPLE_W if snapshot bit v=1, else 0.
REQ-022 Sum SHALL be SAMPLE_W bits; cannot overflow for NUM_VOICES<=8 (max 8*(2^20-1)).
REQ-023 Entering OUT SHALL register sample_out = sum >> 2 and assert sample_valid.
REQ-024 Latency: sample_valid SHALL rise NUM_VOICES+1 cycles after the accepted sample_req.
REQ-025 OUT: sample_out and sample_valid SHALL hold stable until sample_valid&&sample_ready; on transfer, sample_valid deasserts next cycle and FSM goes IDLE.
REQ-026 sample_req coincident with the OUT transfer cycle SHALL be accepted (go directly to ACCUM, no overrun).
REQ-027 sample_req in ACCUM, or in OUT without transfer, SHALL be dropped and overrun pulsed for that cycle only.
REQ-028 inc_wr SHALL update inc[inc_idx] in any state; if inc_idx==v in the same ACCUM cycle, the old increment is used for that sample, new from the next.
REQ-029 voice_en changes after the snapshot SHALL not affect the sample in progress.

Reset
REQ-030 reset SHALL override all inputs including sample_req and inc_wr in the same cycle.
REQ-031 On reset: FSM=IDLE, all phase[] and inc[] = 0, sum=0, v=0.
REQ-032 On reset: sample_out=0, sample_valid=0, busy=0, overrun=0.
REQ-033 Reset mid-ACCUM or mid-OUT SHALL discard the partial/pending sample without emitting it.

Structure
REQ-034 NUM_VOICES default, PHASE_MAX, phase bit-slice constants and FSM state encoding SHALL live in shared package audio_pkg.
REQ-035 Wrap-add of REQ-019 SHALL be a combinational sub-module phase_wrap_add (PHASE_W parameter); all else in voice_sequencer.
REQ-036 phase[] and inc[] SHALL be register arrays indexed by v (single shared adder, no per-voice adders).

Verification
REQ-037 Reset, inc[0]=0x0100_0000, all voice_en=1, others inc=0, one sample_req -> sample_valid at cycle 9, sample_out=0; second sample_req -> sample_out=(0x0100_0000>>8)>>2=0x4000.
REQ-038 inc[3]=0x0F00_0000, three samples -> phase[3] sequence 0, 0x0F00_0000, 0x0E00_0000 (wrap), contributions 0, 0xF0000, 0xE0000 before >>2.
REQ-039 sample_ready held 0 for 20 cycles in OUT, sample_req pulsed at cycle 5 -> sample_out stable, overrun single pulse, one sample delivered on ready.
REQ-040 sample_req on same cycle as OUT transfer -> no overrun, busy stays 1, next sample_valid NUM_VOICES+1 cycles later.
REQ-041 voice_en=0x01 at req, switched to 0xFF during ACCUM -> only voice 0 contributes; all phases still advance.
REQ-042 reset asserted at ACCUM voice 4 -> sample_valid never asserts for that request, all outputs 0 next cycle, phases 0.
